sc_psr_ctrl: RTL and testbench

Controller and arbiter for the 4-bit processor status register {N,Z,V,C}. It is the only block that drives the PSR write port. It arbitrates between ALU condition-code commits and trap entry/return, and keeps a one-deep shadow copy of the flags across a trap. It also evaluates 4-bit SPARC-style branch conditions against the current flags, bypassing any commit that is in flight.

---
 rtl/sc_psr_ctrl_if.sv | 46 ++++
 rtl/sc_psr_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_sc_psr_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sc_psr_ctrl_if.sv
// PSR controller bus: ALU commit handshake, trap control, branch evaluation and PSR write port.
// Optional macro PSR_CTRL_STATS_EN adds the commit counter signal.
interface sc_psr_ctrl_if #(
  parameter int DATAWIDTH_FLAGS = 4
`ifdef PSR_CTRL_STATS_EN
  , parameter int STATS_WIDTH = 16
`endif
);
  logic [DATAWIDTH_FLAGS-1:0] SC_PsrCtrl_PsrValue;
  logic                       SC_PsrCtrl_AluReq;
  logic [DATAWIDTH_FLAGS-1:0] SC_PsrCtrl_AluFlags;
  logic                       SC_PsrCtrl_AluAck;
  logic                       SC_PsrCtrl_TrapReq;
  logic                       SC_PsrCtrl_RetReq;
  logic                       SC_PsrCtrl_InTrap;
  logic                       SC_PsrCtrl_TrapErr;
  logic [3:0]                 SC_PsrCtrl_Cond;
  logic                       SC_PsrCtrl_EvalReq;
  logic                       SC_PsrCtrl_Taken;
  logic                       SC_PsrCtrl_TakenValid;
  logic                       SC_PsrCtrl_PsrWrite_InLow;
  logic [DATAWIDTH_FLAGS-1:0] SC_PsrCtrl_PsrFlags;
`ifdef PSR_CTRL_STATS_EN
  logic [STATS_WIDTH-1:0]     SC_PsrCtrl_CommitCount;
`endif

  modport master (
    output SC_PsrCtrl_PsrValue, SC_PsrCtrl_AluReq, SC_PsrCtrl_AluFlags,
           SC_PsrCtrl_TrapReq, SC_PsrCtrl_RetReq, SC_PsrCtrl_Cond, SC_PsrCtrl_EvalReq,
    input  SC_PsrCtrl_AluAck, SC_PsrCtrl_InTrap, SC_PsrCtrl_TrapErr, SC_PsrCtrl_Taken,
           SC_PsrCtrl_TakenValid, SC_PsrCtrl_PsrWrite_InLow, SC_PsrCtrl_PsrFlags
`ifdef PSR_CTRL_STATS_EN
    , input SC_PsrCtrl_CommitCount
`endif
  );

  modport slave (
    input  SC_PsrCtrl_PsrValue, SC_PsrCtrl_AluReq, SC_PsrCtrl_AluFlags,
           SC_PsrCtrl_TrapReq, SC_PsrCtrl_RetReq, SC_PsrCtrl_Cond, SC_PsrCtrl_EvalReq,
    output SC_PsrCtrl_AluAck, SC_PsrCtrl_InTrap, SC_PsrCtrl_TrapErr, SC_PsrCtrl_Taken,
           SC_PsrCtrl_TakenValid, SC_PsrCtrl_PsrWrite_InLow, SC_PsrCtrl_PsrFlags
`ifdef PSR_CTRL_STATS_EN
    , output SC_PsrCtrl_CommitCount
`endif
  );
endinterface

// File: rtl/sc_psr_ctrl.sv
// PSR {N,Z,V,C} write-port arbiter: ALU commits, trap save/restore, SPARC branch evaluation.
// Optional macro PSR_CTRL_STATS_EN adds a saturating commit counter.
//
// state   | meaning
// INIT    | one write of FLAGS_INIT after reset, requests ignored
// IDLE    | normal context: trap entry, ALU commits
// SAVE    | write 0000, enter trap context
// TRAP    | trap context: return, ALU commits
// RESTORE | write shadow copy, leave trap context
module sc_psr_ctrl #(
  parameter int                         DATAWIDTH_FLAGS = 4,
  parameter logic [DATAWIDTH_FLAGS-1:0] FLAGS_INIT      = 4'b1111
`ifdef PSR_CTRL_STATS_EN
  , parameter int                       STATS_WIDTH     = 16
`endif
) (
  input logic           SC_PsrCtrl_CLOCK_50,
  input logic           SC_PsrCtrl_RESET_InLow,
  sc_psr_ctrl_if.slave  psr_bus
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SAVE,
    ST_TRAP,
    ST_RESTORE
  } state_t;

  state_t                     state_q, state_d;
  logic [DATAWIDTH_FLAGS-1:0] shadow_q, shadow_d;
  logic [DATAWIDTH_FLAGS-1:0] flags_q, flags_d;
  logic [DATAWIDTH_FLAGS-1:0] eval_flags;
  logic                       wr_n_q, wr_n_d;
  logic                       ack_q, ack_d;
  logic                       in_trap_q, in_trap_d;
  logic                       err_q, err_d;
  logic                       taken_q, taken_d;
  logic                       valid_q, valid_d;
`ifdef PSR_CTRL_STATS_EN
  logic [STATS_WIDTH-1:0]     count_q, count_d;
`endif

  function automatic logic cond_taken(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, v, c;
    logic r;
    n = f[3];
    z = f[2];
    v = f[1];
    c = f[0];
    case (cond)
      4'b0000: r = 1'b0;
      4'b0001: r = z;
      4'b0010: r = z | (n ^ v);
      4'b0011: r = n ^ v;
      4'b0100: r = c | z;
      4'b0101: r = c;
      4'b0110: r = n;
      4'b0111: r = v;
      4'b1000: r = 1'b1;
      4'b1001: r = ~z;
      4'b1010: r = ~(z | (n ^ v));
      4'b1011: r = ~(n ^ v);
      4'b1100: r = ~(c | z);
      4'b1101: r = ~c;
      4'b1110: r = ~n;
      default: r = ~v;
    endcase
    return r;
  endfunction

  // A write driven this cycle lands in the PSR only at the next edge, so bypass it.
  assign eval_flags = wr_n_q ? psr_bus.SC_PsrCtrl_PsrValue : flags_q;

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    flags_d   = flags_q;
    wr_n_d    = 1'b1;
    ack_d     = 1'b0;
    in_trap_d = in_trap_q;
    err_d     = err_q;
    taken_d   = taken_q;
    valid_d   = psr_bus.SC_PsrCtrl_EvalReq;

    if (psr_bus.SC_PsrCtrl_EvalReq) begin
      taken_d = cond_taken(psr_bus.SC_PsrCtrl_Cond, eval_flags);
    end

    case (state_q)
      ST_INIT: begin
        wr_n_d  = 1'b0;
        flags_d = FLAGS_INIT;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (psr_bus.SC_PsrCtrl_TrapReq) begin
          shadow_d = psr_bus.SC_PsrCtrl_PsrValue;
          state_d  = ST_SAVE;
        end else if (psr_bus.SC_PsrCtrl_RetReq) begin
          err_d = 1'b1;
        end else if (psr_bus.SC_PsrCtrl_AluReq) begin
          wr_n_d  = 1'b0;
          flags_d = psr_bus.SC_PsrCtrl_AluFlags;
          ack_d   = 1'b1;
        end
      end
      ST_SAVE: begin
        wr_n_d    = 1'b0;
        flags_d   = '0;
        in_trap_d = 1'b1;
        state_d   = ST_TRAP;
      end
      ST_TRAP: begin
        if (psr_bus.SC_PsrCtrl_TrapReq) begin
          err_d = 1'b1;
        end else if (psr_bus.SC_PsrCtrl_RetReq) begin
          state_d = ST_RESTORE;
        end else if (psr_bus.SC_PsrCtrl_AluReq) begin
          wr_n_d  = 1'b0;
          flags_d = psr_bus.SC_PsrCtrl_AluFlags;
          ack_d   = 1'b1;
        end
      end
      ST_RESTORE: begin
        wr_n_d    = 1'b0;
        flags_d   = shadow_q;
        in_trap_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

`ifdef PSR_CTRL_STATS_EN
    count_d = count_q;
    if (ack_d && (count_q != {STATS_WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge SC_PsrCtrl_CLOCK_50) begin
    if (!SC_PsrCtrl_RESET_InLow) begin
      state_q   <= ST_INIT;
      shadow_q  <= FLAGS_INIT;
      flags_q   <= '0;
      wr_n_q    <= 1'b1;
      ack_q     <= 1'b0;
      in_trap_q <= 1'b0;
      err_q     <= 1'b0;
      taken_q   <= 1'b0;
      valid_q   <= 1'b0;
`ifdef PSR_CTRL_STATS_EN
      count_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      flags_q   <= flags_d;
      wr_n_q    <= wr_n_d;
      ack_q     <= ack_d;
      in_trap_q <= in_trap_d;
      err_q     <= err_d;
      taken_q   <= taken_d;
      valid_q   <= valid_d;
`ifdef PSR_CTRL_STATS_EN
      count_q   <= count_d;
`endif
    end
  end

  assign psr_bus.SC_PsrCtrl_AluAck         = ack_q;
  assign psr_bus.SC_PsrCtrl_InTrap         = in_trap_q;
  assign psr_bus.SC_PsrCtrl_TrapErr        = err_q;
  assign psr_bus.SC_PsrCtrl_Taken          = taken_q;
  assign psr_bus.SC_PsrCtrl_TakenValid     = valid_q;
  assign psr_bus.SC_PsrCtrl_PsrWrite_InLow = wr_n_q;
  assign psr_bus.SC_PsrCtrl_PsrFlags       = flags_q;
`ifdef PSR_CTRL_STATS_EN
  assign psr_bus.SC_PsrCtrl_CommitCount    = count_q;
`endif

endmodule

// File: tb/tb_sc_psr_ctrl.sv
// Bench for sc_psr_ctrl: directed trap/commit sequences then random traffic, checked
// against a behavioural model of the PSR, trap context and branch conditions.
module tb_sc_psr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] psr = 4'h0;

  int n_total = 0;
  int n_bad   = 0;

  sc_psr_ctrl_if bus ();

  sc_psr_ctrl dut (
    .SC_PsrCtrl_CLOCK_50    (clk),
    .SC_PsrCtrl_RESET_InLow (rst_n),
    .psr_bus                (bus)
  );

  always #5 clk = ~clk;

  // The processor status register the controller writes into.
  always @(posedge clk) begin
    if (!bus.SC_PsrCtrl_PsrWrite_InLow) psr <= bus.SC_PsrCtrl_PsrFlags;
  end
  assign bus.SC_PsrCtrl_PsrValue = psr;

  // Model state: what the controller should present after each edge.
  bit       m_need_init, m_saving, m_restoring, m_ctx;
  bit       m_in_trap, m_err, m_wr, m_ack, m_valid, m_taken, m_psr_known;
  logic [3:0] m_wflags = 4'h0;
  logic [3:0] m_shadow = 4'hF;
  logic [3:0] m_psr    = 4'h0;
  int       m_count;

  bit         hold_alu;
  logic [3:0] hold_flags;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit branch(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, v, c, base;
    n = f[3]; z = f[2]; v = f[1]; c = f[0];
    case (cond[2:0])
      3'd0: base = 1'b0;
      3'd1: base = z;
      3'd2: base = z || (n != v);
      3'd3: base = (n != v);
      3'd4: base = c || z;
      3'd5: base = c;
      3'd6: base = n;
      default: base = v;
    endcase
    return cond[3] ? !base : base;
  endfunction

  task automatic model_edge(input bit r, trap, ret, alu, input logic [3:0] af,
                            input bit ev, input logic [3:0] cond);
    logic [3:0] old_psr, src;
    bit         was_wr;
    old_psr = m_psr;
    was_wr  = m_wr;
    src     = m_wr ? m_wflags : m_psr;
    m_wr = 0; m_ack = 0; m_valid = 0;
    if (!r) begin
      m_need_init = 1; m_saving = 0; m_restoring = 0; m_ctx = 0;
      m_in_trap = 0; m_err = 0; m_taken = 0; m_wflags = 4'h0; m_shadow = 4'hF;
      m_count = 0;
    end else begin
      m_valid = ev;
      if (ev) m_taken = branch(cond, src);
      if (m_need_init) begin
        m_need_init = 0; m_wr = 1; m_wflags = 4'hF;
      end else if (m_saving) begin
        m_saving = 0; m_wr = 1; m_wflags = 4'h0; m_in_trap = 1; m_ctx = 1;
      end else if (m_restoring) begin
        m_restoring = 0; m_wr = 1; m_wflags = m_shadow; m_in_trap = 0; m_ctx = 0;
      end else if (trap) begin
        if (m_ctx) m_err = 1;
        else begin m_saving = 1; m_shadow = old_psr; end
      end else if (ret) begin
        if (m_ctx) m_restoring = 1;
        else m_err = 1;
      end else if (alu) begin
        m_wr = 1; m_wflags = af; m_ack = 1;
        if (m_count < 65535) m_count++;
      end
    end
    if (was_wr) begin
      m_psr = src;
      m_psr_known = 1;
    end
  endtask

  task automatic step(input bit r, trap, ret, alu, input logic [3:0] af,
                      input bit ev, input logic [3:0] cond);
    @(negedge clk);
    if (hold_alu) begin
      alu = 1'b1;
      af  = hold_flags;
    end
    rst_n                    = r;
    bus.SC_PsrCtrl_TrapReq   = trap;
    bus.SC_PsrCtrl_RetReq    = ret;
    bus.SC_PsrCtrl_AluReq    = alu;
    bus.SC_PsrCtrl_AluFlags  = af;
    bus.SC_PsrCtrl_EvalReq   = ev;
    bus.SC_PsrCtrl_Cond      = cond;
    model_edge(r, trap, ret, alu, af, ev, cond);
    hold_alu   = alu && !m_ack;
    hold_flags = af;
    @(posedge clk);
    #1;
    chk("wr_n",    bus.SC_PsrCtrl_PsrWrite_InLow, !m_wr);
    chk("flags",   bus.SC_PsrCtrl_PsrFlags, m_wflags);
    chk("ack",     bus.SC_PsrCtrl_AluAck, m_ack);
    chk("in_trap", bus.SC_PsrCtrl_InTrap, m_in_trap);
    chk("trap_err", bus.SC_PsrCtrl_TrapErr, m_err);
    chk("t_valid", bus.SC_PsrCtrl_TakenValid, m_valid);
    if (m_valid) chk("taken", bus.SC_PsrCtrl_Taken, m_taken);
    if (m_psr_known) chk("psr", psr, m_psr);
`ifdef PSR_CTRL_STATS_EN
    chk("count", bus.SC_PsrCtrl_CommitCount, m_count);
`endif
  endtask

  initial begin
    bus.SC_PsrCtrl_TrapReq  = 1'b0;
    bus.SC_PsrCtrl_RetReq   = 1'b0;
    bus.SC_PsrCtrl_AluReq   = 1'b0;
    bus.SC_PsrCtrl_AluFlags = 4'h0;
    bus.SC_PsrCtrl_EvalReq  = 1'b0;
    bus.SC_PsrCtrl_Cond     = 4'h0;

    // reset with AluReq held, INIT write, held request acked in IDLE
    step(0, 0, 0, 1, 4'hA, 0, 4'h0);
    step(0, 0, 0, 1, 4'hA, 0, 4'h0);
    step(1, 0, 0, 1, 4'hA, 0, 4'h0);
    step(1, 0, 0, 0, 4'h0, 1, 4'b1000);
    // commit 0100 then evaluate Z during the write cycle
    step(1, 0, 0, 1, 4'b0100, 0, 4'h0);
    step(1, 0, 0, 0, 4'h0, 1, 4'b0001);
    // PSR=1001, trap entry with a colliding commit, error cases, restore
    step(1, 0, 0, 1, 4'b1001, 0, 4'h0);
    step(1, 0, 0, 0, 4'h0, 1, 4'b0110);
    step(1, 0, 0, 0, 4'h0, 1, 4'b0111);
    step(1, 1, 0, 1, 4'b0010, 0, 4'h0);
    step(1, 0, 0, 0, 4'h0, 0, 4'h0);
    step(1, 0, 0, 0, 4'h0, 1, 4'b1001);
    step(1, 0, 0, 0, 4'h0, 1, 4'b0111);
    step(1, 1, 0, 0, 4'h0, 0, 4'h0);
    step(1, 0, 1, 0, 4'h0, 0, 4'h0);
    step(1, 0, 0, 0, 4'h0, 0, 4'h0);
    step(1, 0, 0, 0, 4'h0, 1, 4'b0101);
    step(1, 0, 1, 0, 4'h0, 0, 4'h0);
    step(1, 0, 0, 0, 4'h0, 0, 4'h0);
    // reset in the middle of a trap
    step(1, 1, 0, 0, 4'h0, 0, 4'h0);
    step(1, 0, 0, 0, 4'h0, 0, 4'h0);
    step(1, 0, 0, 0, 4'h0, 0, 4'h0);
    step(0, 0, 0, 0, 4'h0, 0, 4'h0);
    step(1, 0, 0, 0, 4'h0, 0, 4'h0);
    step(1, 0, 1, 0, 4'h0, 0, 4'h0);
    // three commits in a row
    step(1, 0, 0, 1, 4'h3, 0, 4'h0);
    step(1, 0, 0, 1, 4'h5, 1, 4'b1100);
    step(1, 0, 0, 1, 4'h8, 1, 4'b0011);
    step(1, 0, 0, 0, 4'h0, 1, 4'b1010);

    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 199) != 0,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 11) == 0,
           $urandom_range(0, 1) == 1,
           4'($urandom),
           $urandom_range(0, 1) == 1,
           4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
